// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: datapath width, opcode encoding
// and the packed result bundle handed from the core to the output stage.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    ADC  = 4'b0010,
    SBC  = 4'b0011,
    AND  = 4'b0100,
    OR   = 4'b0101,
    NOT  = 4'b0110,
    XNOR = 4'b0111,
    ASR  = 4'b1000,
    LSL  = 4'b1001,
    LSR  = 4'b1010,
    ROL  = 4'b1011,
    ROR  = 4'b1100,
    RRC  = 4'b1101,
    RLC  = 4'b1110,
    PASS = 4'b1111
  } alu_op_e;

  // Registered output bundle; z and n are always derived from y.
  typedef struct packed {
    logic [ALU_W-1:0] y;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
  } alu_res_t;

  function automatic logic is_carry_op(alu_op_e op);
    return (op == ADC) || (op == SBC);
  endfunction

endpackage

// File: rtl/alu_8_bit_if.sv
// Operand/result bundle for the 8-bit ALU. There is no handshake: the
// master presents operands every cycle and qualifies them with en alone.
interface alu_8_bit_if;
  import alu_pkg::*;

  logic             en;
  logic [ALU_W-1:0] d0;
  logic [ALU_W-1:0] d1;
  logic [3:0]       alu_op;
  logic             c_in;
  logic [ALU_W-1:0] y;
  logic             c_out;
  logic             z_out;
  logic             n_out;
  logic             v_out;

  modport master (
    output en, d0, d1, alu_op, c_in,
    input  y, c_out, z_out, n_out, v_out
  );

  modport slave (
    input  en, d0, d1, alu_op, c_in,
    output y, c_out, z_out, n_out, v_out
  );

endinterface

// File: rtl/alu_8_bit_core.sv
// Combinational ALU core: decodes the opcode and produces the next result,
// carry/borrow/shifted-out bit and signed-overflow flag.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] d0,
  input  logic [ALU_W-1:0] d1,
  input  logic [3:0]       alu_op,
  input  logic             c_in,
  output logic [ALU_W-1:0] next_y,
  output logic             next_c,
  output logic             next_v
);

  alu_op_e      op;
  logic         cin_used;
  logic [ALU_W:0] add9;
  logic [ALU_W:0] sub9;

  assign op       = alu_op_e'(alu_op);
  assign cin_used = is_carry_op(op) ? c_in : 1'b0;

  // Bit 8 of the 9-bit difference is the borrow, since both operands are zero-extended.
  assign add9 = {1'b0, d0} + {1'b0, d1} + {{ALU_W{1'b0}}, cin_used};
  assign sub9 = {1'b0, d0} - {1'b0, d1} - {{ALU_W{1'b0}}, cin_used};

  always_comb begin
    next_y = '0;
    next_c = 1'b0;
    next_v = 1'b0;
    case (op)
      ADD, ADC: begin
        next_y = add9[ALU_W-1:0];
        next_c = add9[ALU_W];
        next_v = (d0[ALU_W-1] == d1[ALU_W-1]) && (add9[ALU_W-1] != d0[ALU_W-1]);
      end
      SUB, SBC: begin
        next_y = sub9[ALU_W-1:0];
        next_c = sub9[ALU_W];
        next_v = (d0[ALU_W-1] != d1[ALU_W-1]) && (sub9[ALU_W-1] != d0[ALU_W-1]);
      end
      AND:  next_y = d0 & d1;
      OR:   next_y = d0 | d1;
      NOT:  next_y = ~d0;
      XNOR: next_y = ~(d0 ^ d1);
      ASR: begin
        next_y = {d0[ALU_W-1], d0[ALU_W-1:1]};
        next_c = d0[0];
      end
      LSL: begin
        next_y = {d0[ALU_W-2:0], 1'b0};
        next_c = d0[ALU_W-1];
      end
      LSR: begin
        next_y = {1'b0, d0[ALU_W-1:1]};
        next_c = d0[0];
      end
      ROL: begin
        next_y = {d0[ALU_W-2:0], d0[ALU_W-1]};
        next_c = d0[ALU_W-1];
      end
      ROR: begin
        next_y = {d0[0], d0[ALU_W-1:1]};
        next_c = d0[0];
      end
      RRC: begin
        next_y = {c_in, d0[ALU_W-1:1]};
        next_c = d0[0];
      end
      RLC: begin
        next_y = {d0[ALU_W-2:0], c_in};
        next_c = d0[ALU_W-1];
      end
      PASS: next_y = d0;
      default: begin
        next_y = '0;
        next_c = 1'b0;
        next_v = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_8_bit.sv
// Registered 8-bit ALU: combinational core plus zero/negative derivation
// and enable-gated output registers with asynchronous active-low reset.
module alu_8_bit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_8_bit_if.slave  bus
);

  logic [ALU_W-1:0] next_y;
  logic             next_c;
  logic             next_v;
  alu_res_t         res_d;
  alu_res_t         res_q;

  alu_core u_core (
    .d0     (bus.d0),
    .d1     (bus.d1),
    .alu_op (bus.alu_op),
    .c_in   (bus.c_in),
    .next_y (next_y),
    .next_c (next_c),
    .next_v (next_v)
  );

  // Flags come from the same next_y that is captured, so they never disagree with y.
  always_comb begin
    res_d = res_q;
    if (bus.en) begin
      res_d.y = next_y;
      res_d.c = next_c;
      res_d.z = (next_y == '0);
      res_d.n = next_y[ALU_W-1];
      res_d.v = next_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.y     = res_q.y;
  assign bus.c_out = res_q.c;
  assign bus.z_out = res_q.z;
  assign bus.n_out = res_q.n;
  assign bus.v_out = res_q.v;

endmodule

// File: tb/tb_alu_8_bit.sv
// Bench for alu_8_bit: directed vectors, a randomised back-to-back sweep
// against an integer reference model, enable hold and asynchronous reset.
module tb_alu_8_bit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [11:0] exp_q[$];
  logic [11:0] last_e;

  alu_8_bit_if bus ();

  alu_8_bit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // reference model: packed as {y, c, z, n, v}
  function automatic logic [11:0] model(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic ci);
    int ua, ub, r, sa, sb, sr;
    logic [7:0] y;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 0; sr = 0; y = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin r = ua + ub; sr = sa + sb; y = r[7:0]; c = (r > 255); v = (sr > 127) || (sr < -128); end
      4'h2: begin r = ua + ub + int'(ci); sr = sa + sb + int'(ci); y = r[7:0]; c = (r > 255); v = (sr > 127) || (sr < -128); end
      4'h1: begin r = ua - ub; y = r[7:0]; c = (ua < ub); v = (a[7] != b[7]) && (y[7] != a[7]); end
      4'h3: begin r = ua - ub - int'(ci); y = r[7:0]; c = (ua < ub + int'(ci)); v = (a[7] != b[7]) && (y[7] != a[7]); end
      4'h4: y = a & b;
      4'h5: y = a | b;
      4'h6: y = ~a;
      4'h7: y = ~(a ^ b);
      4'h8: begin y = {a[7], a[7:1]}; c = a[0]; end
      4'h9: begin y = {a[6:0], 1'b0}; c = a[7]; end
      4'hA: begin y = {1'b0, a[7:1]}; c = a[0]; end
      4'hB: begin y = {a[6:0], a[7]}; c = a[7]; end
      4'hC: begin y = {a[0], a[7:1]}; c = a[0]; end
      4'hD: begin y = {ci, a[7:1]}; c = a[0]; end
      4'hE: begin y = {a[6:0], ci}; c = a[7]; end
      default: y = a;
    endcase
    return {y, c, (y == 8'h00), y[7], v};
  endfunction

  // driver: applies one operation and records what the DUT must show after the next edge
  task automatic drive(input logic en_v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [11:0] e);
    bus.en     = en_v;
    bus.alu_op = op;
    bus.d0     = a;
    bus.d1     = b;
    bus.c_in   = ci;
    exp_q.push_back(e);
    last_e = e;
  endtask

  function automatic logic [11:0] observed();
    return {bus.y, bus.c_out, bus.z_out, bus.n_out, bus.v_out};
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0;
    bus.en = 1'b1; bus.alu_op = 4'h6; bus.d0 = 8'h00; bus.d1 = 8'h00; bus.c_in = 1'b0;
    repeat (2) @(negedge clk);
    got = observed();
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL reset_state got=%03h exp=%03h", got, 12'h000);
    end
    bus.en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [3:0]  op_t[6] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3};
    logic [7:0]  a_t[6]  = '{8'h0A, 8'hFF, 8'h0A, 8'h00, 8'hFF, 8'h00};
    logic [7:0]  b_t[6]  = '{8'h05, 8'h01, 8'h05, 8'h01, 8'h01, 8'h01};
    logic        c_t[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [11:0] e_t[6]  = '{{8'h0F, 4'b0000}, {8'h00, 4'b1100}, {8'h05, 4'b0000},
                             {8'hFF, 4'b1010}, {8'h01, 4'b1000}, {8'hFE, 4'b1010}};
    logic [11:0] got, e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, op_t[i], a_t[i], b_t[i], c_t[i], e_t[i]);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL arith[%0d] op=%0h got=%03h exp=%03h", i, op_t[i], got, e);
      end
    end
  endtask

  task automatic test_logic_shift();
    logic [11:0] e_t[9] = '{{8'h00, 4'b0100}, {8'h0F, 4'b0000}, {8'hF5, 4'b0010},
                            {8'hF0, 4'b0010}, {8'h05, 4'b0000}, {8'h14, 4'b0000},
                            {8'h05, 4'b0000}, {8'h14, 4'b0000}, {8'h05, 4'b0000}};
    logic [11:0] got, e;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, 4'(4 + i), 8'h0A, 8'h05, 1'b0, e_t[i]);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL logic_shift op=%0h got=%03h exp=%03h", 4 + i, got, e);
      end
    end
  endtask

  task automatic test_rrc_overflow();
    logic [3:0]  op_t[3] = '{4'hD, 4'hD, 4'h0};
    logic [7:0]  a_t[3]  = '{8'h0A, 8'hFF, 8'h7F};
    logic [7:0]  b_t[3]  = '{8'h00, 8'h00, 8'h01};
    logic        c_t[3]  = '{1'b1, 1'b1, 1'b0};
    logic [11:0] e_t[3]  = '{{8'h85, 4'b0010}, {8'hFF, 4'b1010}, {8'h80, 4'b0011}};
    logic [11:0] got, e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, op_t[i], a_t[i], b_t[i], c_t[i], e_t[i]);
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rrc_ovf[%0d] got=%03h exp=%03h", i, got, e);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [11:0] got, e;
    @(negedge clk);
    drive(1'b0, 4'h0, 8'hFF, 8'hFF, 1'b1, {8'h80, 4'b0011});
    repeat (3) begin
      @(negedge clk);
      bus.d0 = 8'($urandom_range(0, 255));
      bus.alu_op = 4'($urandom_range(0, 15));
    end
    got = observed();
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL enable_hold got=%03h exp=%03h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic        ci, en_v;
    logic [11:0] got, e;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        got = observed();
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL back_to_back[%0d] got=%03h exp=%03h", i, got, e);
        end
      end
      op   = 4'($urandom_range(0, 15));
      a    = 8'($urandom_range(0, 255));
      b    = 8'($urandom_range(0, 255));
      ci   = 1'($urandom_range(0, 1));
      en_v = ($urandom_range(0, 3) != 0);
      drive(en_v, op, a, b, ci, en_v ? model(op, a, b, ci) : last_e);
    end
    @(negedge clk);
    got = observed();
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL back_to_back_last got=%03h exp=%03h", got, e);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] got, e;
    @(negedge clk);
    drive(1'b1, 4'hF, 8'h55, 8'h00, 1'b0, {8'h55, 4'b0000});
    @(negedge clk);
    got = observed();
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL pre_reset got=%03h exp=%03h", got, e);
    end
    // assert reset between edges; outputs must clear without a clock edge
    @(posedge clk);
    #2;
    bus.d0 = 8'hAA;
    rst_n = 1'b0;
    #1;
    got = observed();
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL async_reset got=%03h exp=%03h", got, 12'h000);
    end
    @(negedge clk);
    got = observed();
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL reset_hold got=%03h exp=%03h", got, 12'h000);
    end
    rst_n = 1'b1;
    drive(1'b1, 4'hF, 8'hAA, 8'h00, 1'b0, {8'hAA, 4'b0010});
    @(negedge clk);
    got = observed();
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL post_reset_capture got=%03h exp=%03h", got, e);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    last_e = 12'h000;
    test_reset();
    test_arith();
    test_logic_shift();
    test_rrc_overflow();
    test_enable_hold();
    test_back_to_back();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=%0d", exp_q.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
